// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA cursor/grid renderer.
package vga_pkg;

  typedef logic [11:0] rgb12_t;
  typedef logic [4:0]  cell_t;

  localparam int CELL_SHIFT = 5;
  localparam int N_COLS     = 32;
  localparam int N_ROWS     = 24;

  localparam rgb12_t BG_DEFAULT     = 12'h000;
  localparam rgb12_t GRID_DEFAULT   = 12'h444;
  localparam rgb12_t CURSOR_DEFAULT = 12'hF80;

endpackage

// File: rtl/vga_cursor_grid_renderer_cursor_ctrl.sv
// Cursor position register with sticky move requests, applied only at frame start.
module cursor_ctrl
  import vga_pkg::*;
#(
  parameter int INIT_COL = 0,
  parameter int INIT_ROW = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  frame_start,
  input  logic  mv_up,
  input  logic  mv_down,
  input  logic  mv_left,
  input  logic  mv_right,
  output cell_t cur_col,
  output cell_t cur_row
);

  localparam cell_t COL_MAX = cell_t'(N_COLS - 1);
  localparam cell_t ROW_MAX = cell_t'(N_ROWS - 1);

  // Pending flags ordered {up, down, left, right}.
  logic [3:0] pend_q, pend_d, pulses;
  cell_t      col_q, col_d, row_q, row_d;

  assign pulses = {mv_up, mv_down, mv_left, mv_right};

  always_comb begin
    pend_d = pend_q | pulses;
    col_d  = col_q;
    row_d  = row_q;
    if (frame_start) begin
      // A pulse landing on the frame-start cycle waits for the next frame.
      pend_d = pulses;
      if (pend_q[0] && !pend_q[1] && col_q != COL_MAX) col_d = col_q + 5'd1;
      else if (pend_q[1] && !pend_q[0] && col_q != '0) col_d = col_q - 5'd1;
      if (pend_q[2] && !pend_q[3] && row_q != ROW_MAX) row_d = row_q + 5'd1;
      else if (pend_q[3] && !pend_q[2] && row_q != '0) row_d = row_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      col_q  <= cell_t'(INIT_COL);
      row_q  <= cell_t'(INIT_ROW);
    end else begin
      pend_q <= pend_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign cur_col = col_q;
  assign cur_row = row_q;

endmodule

// File: rtl/vga_cursor_grid_renderer.sv
// Two-stage pixel pipeline drawing a 32x24 cell grid with one highlighted cursor cell.
module vga_cursor_grid_renderer
  import vga_pkg::*;
#(
  parameter rgb12_t BG_COLOR     = BG_DEFAULT,
  parameter rgb12_t GRID_COLOR   = GRID_DEFAULT,
  parameter rgb12_t CURSOR_COLOR = CURSOR_DEFAULT,
  parameter int     INIT_COL     = 0,
  parameter int     INIT_ROW     = 0
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic [9:0] hc_visible,
  input  logic [9:0] vc_visible,
  input  logic       hs,
  input  logic       vs,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  output rgb12_t     rgb,
  output logic       hs_out,
  output logic       vs_out
);

  function automatic rgb12_t pick_color(input logic act, input logic match, input logic grid);
    if (!act)       return 12'h000;
    else if (match) return CURSOR_COLOR;
    else if (grid)  return GRID_COLOR;
    else            return BG_COLOR;
  endfunction

  cell_t  cur_col, cur_row;
  logic   frame_start;
  logic   act_s0, match_s0, grid_s0;
  logic   act_p1_q, match_p1_q, grid_p1_q, hs_p1_q, vs_p1_q;
  rgb12_t rgb_p2_q;
  logic   hs_p2_q, vs_p2_q;

  assign frame_start = vs_p1_q & ~vs;

  cursor_ctrl #(
    .INIT_COL (INIT_COL),
    .INIT_ROW (INIT_ROW)
  ) u_cursor_ctrl (
    .clk         (clk_vga),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .mv_up       (mv_up),
    .mv_down     (mv_down),
    .mv_left     (mv_left),
    .mv_right    (mv_right),
    .cur_col     (cur_col),
    .cur_row     (cur_row)
  );

  assign act_s0   = (hc_visible != '0) && (vc_visible != '0);
  assign match_s0 = (hc_visible[9:CELL_SHIFT] == cur_col) && (vc_visible[9:CELL_SHIFT] == cur_row);
  assign grid_s0  = (hc_visible[CELL_SHIFT-1:0] == '0) || (vc_visible[CELL_SHIFT-1:0] == '0);

  // Stage 1: pixel classification and syncs
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      act_p1_q   <= 1'b0;
      match_p1_q <= 1'b0;
      grid_p1_q  <= 1'b0;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
    end else begin
      act_p1_q   <= act_s0;
      match_p1_q <= match_s0;
      grid_p1_q  <= grid_s0;
      hs_p1_q    <= hs;
      vs_p1_q    <= vs;
    end
  end

  // Stage 2: colour and aligned syncs
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2_q <= 12'h000;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
    end else begin
      rgb_p2_q <= pick_color(act_p1_q, match_p1_q, grid_p1_q);
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign rgb    = rgb_p2_q;
  assign hs_out = hs_p2_q;
  assign vs_out = vs_p2_q;

endmodule

// File: tb/tb_vga_cursor_grid_renderer.sv
// Directed bench for the cursor/grid renderer: reset, colours, sync delay and cursor moves.
module tb_vga_cursor_grid_renderer;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic [9:0]  hc_visible, vc_visible;
  logic        hs, vs;
  logic        mv_up, mv_down, mv_left, mv_right;
  logic [11:0] rgb;
  logic        hs_out, vs_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk_vga = ~clk_vga;

  vga_cursor_grid_renderer dut (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .hc_visible (hc_visible),
    .vc_visible (vc_visible),
    .hs         (hs),
    .vs         (vs),
    .mv_up      (mv_up),
    .mv_down    (mv_down),
    .mv_left    (mv_left),
    .mv_right   (mv_right),
    .rgb        (rgb),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // Drive one pixel and check the colour that emerges two edges later.
  task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
    @(negedge clk_vga);
    hc_visible = 10'(h);
    vc_visible = 10'(v);
    @(posedge clk_vga);
    @(posedge clk_vga);
    #1;
    check_eq(tag, rgb, exp);
    @(negedge clk_vga);
    hc_visible = '0;
    vc_visible = '0;
  endtask

  task automatic frame_start();
    @(negedge clk_vga);
    vs = 1'b0;
    @(negedge clk_vga);
    vs = 1'b1;
    repeat (2) @(negedge clk_vga);
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right
  task automatic pulse(input int dir);
    @(negedge clk_vga);
    mv_up    = (dir == 0);
    mv_down  = (dir == 1);
    mv_left  = (dir == 2);
    mv_right = (dir == 3);
    @(negedge clk_vga);
    {mv_up, mv_down, mv_left, mv_right} = '0;
  endtask

  logic [9:0] hs_pat;
  logic       hs_exp;

  initial begin
    rst_n = 1'b0;
    hc_visible = '0; vc_visible = '0;
    hs = 1'b1; vs = 1'b1;
    {mv_up, mv_down, mv_left, mv_right} = '0;
    repeat (3) @(negedge clk_vga);
    check_eq("reset_rgb", rgb, 12'h000);
    check_eq("reset_hs", {11'd0, hs_out}, 12'd1);
    check_eq("reset_vs", {11'd0, vs_out}, 12'd1);
    rst_n = 1'b1;

    // Latency: blank before, cursor pixel shows after exactly two edges
    @(negedge clk_vga);
    hc_visible = 10'd10; vc_visible = 10'd10; hs = 1'b0;
    @(posedge clk_vga); #1;
    check_eq("lat_1cyc", rgb, 12'h000);
    @(posedge clk_vga); #1;
    check_eq("lat_2cyc", rgb, 12'hF80);
    check_eq("hs_mid_line", {11'd0, hs_out}, 12'd0);

    // Asynchronous reset in the middle of a line
    @(negedge clk_vga);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_rgb", rgb, 12'h000);
    check_eq("async_rst_hs", {11'd0, hs_out}, 12'd1);
    check_eq("async_rst_vs", {11'd0, vs_out}, 12'd1);
    @(negedge clk_vga);
    hs = 1'b1; hc_visible = '0; vc_visible = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk_vga);

    // Grid, background and blanking with cursor at (0,0)
    pix("grid_64_100", 64, 100, 12'h444);
    pix("bg_70_100", 70, 100, 12'h000);
    pix("blank_0_500", 0, 500, 12'h000);
    pix("blank_500_0", 500, 0, 12'h000);
    pix("cursor_grid_32_0", 1, 32, 12'h444);
    pix("cursor_1_1", 1, 1, 12'hF80);

    // hs pulse reproduced two cycles later with the same width
    hs_pat = 10'b1111100011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_vga);
      hs_exp = (i >= 2) ? hs_pat[i-2] : 1'b1;
      check_eq($sformatf("hs_delay_%0d", i), {11'd0, hs_out}, {11'd0, hs_exp});
      hs = hs_pat[i];
    end
    @(negedge clk_vga);
    hs = 1'b1;

    // Deferred move: no change until frame start
    pulse(3);
    pix("defer_40_10_a", 40, 10, 12'h000);
    pix("defer_40_10_b", 40, 10, 12'h000);
    pix("defer_old_cur", 10, 10, 12'hF80);
    frame_start();
    pix("moved_40_10", 40, 10, 12'hF80);
    pix("moved_grid_in_cell", 32, 10, 12'hF80);
    pix("old_cell_bg", 10, 10, 12'h000);

    // Up at row 0 saturates
    pulse(0);
    frame_start();
    pix("sat_up_row0", 40, 10, 12'hF80);

    // Left and right cancel
    pulse(2);
    pulse(3);
    frame_start();
    pix("lr_cancel", 40, 10, 12'hF80);

    // Repeated down pulses collapse to one step
    pulse(1); pulse(1); pulse(1);
    frame_start();
    pix("down3_row1", 40, 42, 12'hF80);
    pix("down3_not_row2", 40, 74, 12'h000);
    pix("down3_row0_off", 40, 10, 12'h000);

    // Pulse coinciding with the frame-start cycle is deferred one frame
    @(negedge clk_vga);
    vs = 1'b0; mv_down = 1'b1;
    @(negedge clk_vga);
    vs = 1'b1; mv_down = 1'b0;
    repeat (2) @(negedge clk_vga);
    pix("coinc_same_frame", 40, 42, 12'hF80);
    frame_start();
    pix("coinc_next_frame", 40, 74, 12'hF80);
    pix("vs_out_idle", 40, 74, 12'hF80);
    check_eq("vs_out_high", {11'd0, vs_out}, 12'd1);

    // Drive the cursor to the right edge and past it
    for (int i = 0; i < 32; i++) begin
      pulse(3);
      frame_start();
    end
    pix("sat_right_col31", 1002, 74, 12'hF80);
    pix("sat_right_col30_off", 970, 74, 12'h000);
    pix("right_edge_1023", 1023, 74, 12'hF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_cursor_grid_renderer.md
# vga_cursor_grid_renderer

Pixel-generation stage directly downstream of the 1024x768 VGA timing driver. Consumes the driver's visible-pixel coordinates and sync pulses and draws a 32x24 grid of 32x32-pixel cells with one highlighted cursor cell. The cursor is moved by single-cycle button pulses, and moves take effect only at frame start (tear-free). Produces registered 12-bit RGB (4:4:4) plus sync outputs delayed to match.

## Interface
Parameters:
- `BG_COLOR`, 12'h000, background colour
- `GRID_COLOR`, 12'h444, grid-line colour
- `CURSOR_COLOR`, 12'hF80, cursor-cell fill colour
- `INIT_COL`, 0, cursor column after reset (0..31)
- `INIT_ROW`, 0, cursor row after reset (0..23)

Ports:
- `clk_vga`  in  1  pixel clock, same clock as the timing driver
- `rst_n`  in  1  asynchronous, active-low reset
- `hc_visible`  in  10  visible x, 1..1023; 0 = blanking
- `vc_visible`  in  10  visible y, 1..767; 0 = blanking
- `hs`, `vs`  in  1 each  sync pulses from driver, active-low
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  single-cycle move requests, synchronous to `clk_vga`
- `rgb`  out  12  {R[3:0],G[3:0],B[3:0]}
- `hs_out`, `vs_out`  out  1 each  `hs`/`vs` delayed to align with `rgb`

## Operation
- Active pixel: `hc_visible != 0` and `vc_visible != 0`. Otherwise `rgb = 0`, never `BG_COLOR`.
- Cell coordinates: `col = hc_visible[9:5]` (0..31), `row = vc_visible[9:5]` (0..23).
- Colour priority for active pixels, highest first:
  - cursor cell (`col==cur_col && row==cur_row`): `CURSOR_COLOR`, including any grid lines inside the cell
  - grid line (`hc_visible[4:0]==0` or `vc_visible[4:0]==0`): `GRID_COLOR`
  - otherwise `BG_COLOR`
- Move requests:
  - Each pulse sets a sticky pending flag for its direction.
  - Several pulses in one direction within one frame give one step.
  - Flags are applied and cleared at frame start.
- Frame start is the `vs` falling edge: stage-1 registered `vs` is 1 and input `vs` is 0.
- Step rules at frame start:
  - up and down both pending: no vertical move. Left and right both pending: no horizontal move.
  - Horizontal and vertical moves apply in the same frame.
  - Saturation, no wrap: col 0..31, row 0..23. Right at col 31 stays 31; up at row 0 stays 0.
  - A pulse arriving in the same cycle as frame start is not applied. It stays pending for the next frame.
- Cursor registers change only at frame start, so the cursor never changes mid-frame.

## Timing
- Two-stage pipeline, latency 2 cycles from inputs to `rgb`/`hs_out`/`vs_out`.
  - Stage 1 registers coordinates, active flag, cell-match, grid-line and syncs.
  - Stage 2 registers colour and syncs.
- Updated cursor is visible from the first active pixel after the frame-start edge. The `vs` low period plus back porch (>30 lines) guarantees this.
- Reset values (asynchronous, immediate on `rst_n` low):
  - `rgb = 12'h000`, `hs_out = 1`, `vs_out = 1`
  - all pipeline registers inactive, syncs high
  - pending flags 0
  - cursor = (`INIT_COL`, `INIT_ROW`)
- Reset mid-frame: outputs go to reset values at once. Operation resumes 2 cycles after `rst_n` rises. No false frame start is taken on the first cycle, because the registered `vs` resets to 1 and the input `vs` is already high.

## Structure
- Package `vga_pkg`:
  - `rgb12_t` (12-bit logic)
  - `CELL_SHIFT = 5`
  - `N_COLS = 32`, `N_ROWS = 24`
  - default colour constants
- Sub-module `cursor_ctrl`:
  - inputs: clk, reset, `frame_start`, four move pulses
  - outputs: `cur_col[4:0]`, `cur_row[4:0]`
  - holds pending flags and saturating update logic
- Top level holds the pipeline, frame-start detection and colour mux.

## Test plan
- Reset:
  - Hold `rst_n=0` mid-line → `rgb=000`, `hs_out=vs_out=1`.
  - Release with cursor (0,0); drive (`hc_visible`=10, `vc_visible`=10) → `rgb=F80` exactly 2 cycles later.
- Grid and background with cursor at (0,0):
  - (64,100) → `444`; (70,100) → `000`; (0,500) → `000` (blanking).
  - `hs` low pulse reproduced on `hs_out` 2 cycles later, same width.
- Deferred move: pulse `mv_right` mid-frame.
  - Pixel (40,10) stays `444`/`000` for the rest of the frame.
  - After the next `vs` falling edge, (40,10) → `F80`.
- Saturation:
  - `INIT_COL=31`, `mv_right` then frame start → cursor stays col 31.
  - `mv_up` at row 0 → row stays 0.
- Conflicts and collapse:
  - `mv_left` and `mv_right` in one frame → no move.
  - Three `mv_down` pulses in one frame → row +1 only.
- Edge coincidence: `mv_down` in the exact frame-start cycle → no move this frame; row +1 at the following frame start.
